// File: rtl/intc_prio.sv
// Prioritised, edge-latching interrupt controller with request/ack/fin handshake to the CPU.
// Define INTC_NESTING_EN to let a higher-priority channel preempt one already in service.
module intc_prio #(
    parameter int unsigned      N_CH       = 4,
    parameter int unsigned      VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(10'h3C0),
    parameter int unsigned      VEC_STRIDE = 4,
    parameter logic [N_CH-1:0]  MASK_RST   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  irq,
    input  logic             mask_we,
    input  logic [N_CH-1:0]  mask_wdata,
    input  logic             int_ack,
    input  logic             int_fin,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  active,
    output logic [N_CH-1:0]  mask
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   irq_q;
    logic [N_CH-1:0]   pending_q, pending_d, pending_clr;
    logic [N_CH-1:0]   active_q, active_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic              req_q, req_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [CH_W-1:0]   req_ch_q, req_ch_d;

    logic [N_CH-1:0]   rise, eligible;
    logic              any_elig;
    logic [CH_W-1:0]   winner;
    logic [VEC_W-1:0]  vector;

    always_comb begin
        rise     = irq & ~irq_q;
        eligible = pending_q & mask_q;
        any_elig = |eligible;
        winner   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CH_W'(i);
        end
        // Truncation to VEC_W gives the required modulo wrap.
        vector = VEC_BASE + VEC_W'(32'(winner) * VEC_STRIDE);
    end

`ifdef INTC_NESTING_EN
    logic [CH_W-1:0] act_lo;
    logic            preempt;

    always_comb begin
        act_lo = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (active_q[i]) act_lo = CH_W'(i);
        end
        preempt = any_elig && (winner < act_lo);
    end
`endif

    always_comb begin
        state_d     = state_q;
        pending_clr = '0;
        active_d    = active_q;
        req_d       = req_q;
        vec_d       = vec_q;
        req_ch_d    = req_ch_q;
        mask_d      = mask_we ? mask_wdata : mask_q;

        unique case (state_q)
            StIdle: begin
                if (any_elig) begin
                    state_d  = StReq;
                    req_d    = 1'b1;
                    vec_d    = vector;
                    req_ch_d = winner;
                end
            end
            StReq: begin
                // Request is committed: later mask writes do not withdraw it.
                if (int_ack) begin
                    pending_clr[req_ch_q] = 1'b1;
                    active_d[req_ch_q]    = 1'b1;
                    req_d                 = 1'b0;
                    state_d               = StServ;
                end
            end
            StServ: begin
                if (int_fin) begin
                    active_d = active_q & (active_q - N_CH'(1));
                    if (active_d == '0) state_d = StIdle;
                end
`ifdef INTC_NESTING_EN
                if (preempt && (active_d != '0)) begin
                    state_d  = StReq;
                    req_d    = 1'b1;
                    vec_d    = vector;
                    req_ch_d = winner;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // A new rise wins over an ack clearing the same bit.
        pending_d = (pending_q & ~pending_clr) | rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            irq_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            mask_q    <= MASK_RST;
            req_q     <= 1'b0;
            vec_q     <= '0;
            req_ch_q  <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            active_q  <= active_d;
            mask_q    <= mask_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            req_ch_q  <= req_ch_d;
        end
    end

    assign int_req = req_q;
    assign int_vec = vec_q;
    assign pending = pending_q;
    assign active  = active_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_intc_prio.sv
// Directed bench for intc_prio: single request, priority/mask, level irq, edge on ack,
// nesting (either build), and reset in the middle of a request.
module tb_intc_prio;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_ack;
    logic       int_fin;
    logic       int_req;
    logic [9:0] int_vec;
    logic [3:0] pending;
    logic [3:0] active;
    logic [3:0] mask;

    int errors = 0;
    int checks = 0;

    intc_prio dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .int_fin    (int_fin),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .active     (active),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic do_fin();
        int_fin = 1'b1; tick(); int_fin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        if (int_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", int_req); errors++; end
        checks++;
        if (int_vec !== 10'h000) begin $display("FAIL rst_vec: got %h want 000", int_vec); errors++; end
        checks++;
        if (pending !== 4'h0 || active !== 4'h0) begin
            $display("FAIL rst_pend_act: got %b/%b want 0000/0000", pending, active); errors++;
        end
        checks++;
        if (mask !== 4'hF) begin $display("FAIL rst_mask: got %b want 1111", mask); errors++; end
        checks++;
    endtask

    task automatic test_single();
        irq = 4'b0100; tick(); irq = 4'b0000;
        if (pending !== 4'b0100 || int_req !== 1'b0) begin
            $display("FAIL single_pend: got pend=%b req=%b want 0100/0", pending, int_req); errors++;
        end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C8) begin
            $display("FAIL single_req: got req=%b vec=%h want 1/3c8", int_req, int_vec); errors++;
        end
        checks++;
        do_ack();
        if (int_req !== 1'b0 || active !== 4'b0100 || pending !== 4'b0000) begin
            $display("FAIL single_ack: got req=%b act=%b pend=%b want 0/0100/0000",
                     int_req, active, pending); errors++;
        end
        checks++;
        do_fin();
        tick();
        if (active !== 4'b0000 || int_req !== 1'b0) begin
            $display("FAIL single_fin: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
    endtask

    task automatic test_priority_mask();
        mask_we = 1'b1; mask_wdata = 4'b1101; tick(); mask_we = 1'b0;
        if (mask !== 4'b1101) begin $display("FAIL mask_wr: got %b want 1101", mask); errors++; end
        checks++;
        irq = 4'b1010; tick(); irq = 4'b0000;
        if (pending !== 4'b1010) begin $display("FAIL prio_pend: got %b want 1010", pending); errors++; end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3CC) begin
            $display("FAIL prio_req: got req=%b vec=%h want 1/3cc", int_req, int_vec); errors++;
        end
        checks++;
        mask_we = 1'b1; mask_wdata = 4'hF; tick(); mask_we = 1'b0;
        if (int_req !== 1'b1 || int_vec !== 10'h3CC) begin
            $display("FAIL prio_frozen: got req=%b vec=%h want 1/3cc", int_req, int_vec); errors++;
        end
        checks++;
        do_ack();
        if (pending !== 4'b0010 || active !== 4'b1000) begin
            $display("FAIL prio_ack: got pend=%b act=%b want 0010/1000", pending, active); errors++;
        end
        checks++;
        do_fin();
        if (active !== 4'b0000 || int_req !== 1'b0) begin
            $display("FAIL prio_fin: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C4) begin
            $display("FAIL prio_next: got req=%b vec=%h want 1/3c4", int_req, int_vec); errors++;
        end
        checks++;
        do_ack(); do_fin();
    endtask

    task automatic test_level();
        int bad = 0;
        irq = 4'b0001; tick();
        if (pending !== 4'b0001) begin $display("FAIL level_pend: got %b want 0001", pending); errors++; end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C0) begin
            $display("FAIL level_req: got req=%b vec=%h want 1/3c0", int_req, int_vec); errors++;
        end
        checks++;
        do_ack(); do_fin();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (int_req !== 1'b0 || pending !== 4'b0000) bad++;
        end
        if (bad != 0) begin $display("FAIL level_once: got %0d bad cycles want 0", bad); errors++; end
        checks++;
        irq = 4'b0000; tick(); irq = 4'b0001; tick();
        if (pending !== 4'b0001) begin $display("FAIL level_rearm: got %b want 0001", pending); errors++; end
        checks++;
        irq = 4'b0000;
        tick();
        do_ack(); do_fin();
    endtask

    task automatic test_edge_on_ack();
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C8) begin
            $display("FAIL eack_req: got req=%b vec=%h want 1/3c8", int_req, int_vec); errors++;
        end
        checks++;
        irq = 4'b0100; int_ack = 1'b1; tick(); irq = 4'b0000; int_ack = 1'b0;
        if (pending !== 4'b0100 || active !== 4'b0100 || int_req !== 1'b0) begin
            $display("FAIL eack_set_wins: got pend=%b act=%b req=%b want 0100/0100/0",
                     pending, active, int_req); errors++;
        end
        checks++;
        do_fin();
        if (active !== 4'b0000 || int_req !== 1'b0) begin
            $display("FAIL eack_fin: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C8) begin
            $display("FAIL eack_second: got req=%b vec=%h want 1/3c8", int_req, int_vec); errors++;
        end
        checks++;
        do_ack(); do_fin();
    endtask

    task automatic test_nesting();
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        do_ack();
        irq = 4'b0001; tick(); irq = 4'b0000;
        if (pending !== 4'b0001 || active !== 4'b0100) begin
            $display("FAIL nest_pend: got pend=%b act=%b want 0001/0100", pending, active); errors++;
        end
        checks++;
        tick();
`ifdef INTC_NESTING_EN
        if (int_req !== 1'b1 || int_vec !== 10'h3C0 || active !== 4'b0100) begin
            $display("FAIL nest_preempt: got req=%b vec=%h act=%b want 1/3c0/0100",
                     int_req, int_vec, active); errors++;
        end
        checks++;
        do_ack();
        if (active !== 4'b0101 || pending !== 4'b0000) begin
            $display("FAIL nest_ack: got act=%b pend=%b want 0101/0000", active, pending); errors++;
        end
        checks++;
        do_fin();
        if (active !== 4'b0100 || int_req !== 1'b0) begin
            $display("FAIL nest_fin1: got act=%b req=%b want 0100/0", active, int_req); errors++;
        end
        checks++;
        do_fin();
        tick();
        if (active !== 4'b0000 || int_req !== 1'b0) begin
            $display("FAIL nest_fin2: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
`else
        if (int_req !== 1'b0) begin
            $display("FAIL nest_blocked: got req=%b want 0", int_req); errors++;
        end
        checks++;
        do_fin();
        if (active !== 4'b0000 || int_req !== 1'b0) begin
            $display("FAIL nest_fin: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
        tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C0) begin
            $display("FAIL nest_late_req: got req=%b vec=%h want 1/3c0", int_req, int_vec); errors++;
        end
        checks++;
        do_ack();
        if (active !== 4'b0001) begin $display("FAIL nest_late_ack: got %b want 0001", active); errors++; end
        checks++;
        do_fin();
`endif
    endtask

    task automatic test_reset_mid_req();
        mask_we = 1'b1; mask_wdata = 4'b0011; tick(); mask_we = 1'b0;
        irq = 4'b0010; tick(); irq = 4'b0000; tick();
        if (int_req !== 1'b1 || int_vec !== 10'h3C4) begin
            $display("FAIL rreq_req: got req=%b vec=%h want 1/3c4", int_req, int_vec); errors++;
        end
        checks++;
        irq = 4'b1000; tick(); irq = 4'b0000;
        if (pending !== 4'b1010) begin $display("FAIL rreq_pend: got %b want 1010", pending); errors++; end
        checks++;
        reset = 1'b1;
        #1;
        if (int_req !== 1'b0 || int_vec !== 10'h000 || pending !== 4'h0 || active !== 4'h0) begin
            $display("FAIL rreq_async: got req=%b vec=%h pend=%b act=%b want 0/000/0000/0000",
                     int_req, int_vec, pending, active); errors++;
        end
        checks++;
        if (mask !== 4'hF) begin $display("FAIL rreq_mask: got %b want 1111", mask); errors++; end
        checks++;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        if (int_req !== 1'b0 || pending !== 4'h0) begin
            $display("FAIL rreq_quiet: got req=%b pend=%b want 0/0000", int_req, pending); errors++;
        end
        checks++;
        do_ack(); do_fin();
        if (active !== 4'h0 || int_req !== 1'b0) begin
            $display("FAIL stray_ack: got act=%b req=%b want 0000/0", active, int_req); errors++;
        end
        checks++;
    endtask

    initial begin
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; int_fin = 1'b0;
        test_reset();
        test_single();
        test_priority_mask();
        test_level();
        test_edge_on_ack();
        test_nesting();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
